// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one CPU memory bus between the fetch port and the load/store port.
// Latency : request seen in IDLE at cycle 0 -> strobes cycles 1..RAM_LAT -> ack at RAM_LAT+1.
// Backpr. : requesters hold req until ack; inputs are only sampled in IDLE (one access in flight).
//
// Ports
//   i_clk, i_reset                 clock (rising edge), synchronous active-high reset
//   i_if_req/i_if_addr             fetch request (read only) and address
//   o_if_ack/o_if_rdata            one-cycle fetch done pulse, fetched word (held until next ack)
//   i_ls_req/i_ls_we/i_ls_addr     load/store request, 1=store, effective address
//   i_ls_wdata                     store data
//   o_ls_ack/o_ls_rdata            one-cycle load/store done pulse, loaded word
//   o_bus_addr/o_bus_wdata         memory address and write data toward bus_data
//   o_bus_wdata_oe                 1 = top level drives bus_data with o_bus_wdata
//   i_bus_rdata                    bus_data as seen by the CPU
//   o_ram_cs/o_ram_we/o_ram_oe     RAM strobes
//   o_busy                         1 while an access is in progress
module mem_bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int RAM_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ack,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_ls_wdata,
    output logic              o_ls_ack,
    output logic [DATA_W-1:0] o_ls_rdata,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    output logic              o_bus_wdata_oe,
    input  logic [DATA_W-1:0] i_bus_rdata,
    output logic              o_ram_cs,
    output logic              o_ram_we,
    output logic              o_ram_oe,
    output logic              o_busy
);

    localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Registered state
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_gnt_ls;     // port owning the current access
    logic              r_last_ls;    // port granted last (0 = fetch)
    logic              r_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic              r_bus_wdata_oe;
    logic              r_ram_cs;
    logic              r_ram_we;
    logic              r_ram_oe;
    logic              r_if_ack;
    logic              r_ls_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_busy;

    // Next-state values
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_gnt_ls_nxt;
    logic              w_last_ls_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_bus_addr_nxt;
    logic [DATA_W-1:0] w_bus_wdata_nxt;
    logic              w_bus_wdata_oe_nxt;
    logic              w_ram_cs_nxt;
    logic              w_ram_we_nxt;
    logic              w_ram_oe_nxt;
    logic              w_if_ack_nxt;
    logic              w_ls_ack_nxt;
    logic [DATA_W-1:0] w_if_rdata_nxt;
    logic [DATA_W-1:0] w_ls_rdata_nxt;
    logic              w_pick_ls;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_gnt_ls       <= 1'b0;
            r_last_ls      <= 1'b0;
            r_we           <= 1'b0;
            r_bus_addr     <= '0;
            r_bus_wdata    <= '0;
            r_bus_wdata_oe <= 1'b0;
            r_ram_cs       <= 1'b0;
            r_ram_we       <= 1'b0;
            r_ram_oe       <= 1'b0;
            r_if_ack       <= 1'b0;
            r_ls_ack       <= 1'b0;
            r_if_rdata     <= '0;
            r_ls_rdata     <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_gnt_ls       <= w_gnt_ls_nxt;
            r_last_ls      <= w_last_ls_nxt;
            r_we           <= w_we_nxt;
            r_bus_addr     <= w_bus_addr_nxt;
            r_bus_wdata    <= w_bus_wdata_nxt;
            r_bus_wdata_oe <= w_bus_wdata_oe_nxt;
            r_ram_cs       <= w_ram_cs_nxt;
            r_ram_we       <= w_ram_we_nxt;
            r_ram_oe       <= w_ram_oe_nxt;
            r_if_ack       <= w_if_ack_nxt;
            r_ls_ack       <= w_ls_ack_nxt;
            r_if_rdata     <= w_if_rdata_nxt;
            r_ls_rdata     <= w_ls_rdata_nxt;
            r_busy         <= (w_state_nxt != ST_IDLE);
        end
    end

    // Outputs are all registered; the comb block computes their values for the next cycle.
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_gnt_ls_nxt       = r_gnt_ls;
        w_last_ls_nxt      = r_last_ls;
        w_we_nxt           = r_we;
        w_bus_addr_nxt     = r_bus_addr;
        w_bus_wdata_nxt    = r_bus_wdata;
        w_bus_wdata_oe_nxt = 1'b0;
        w_ram_cs_nxt       = 1'b0;
        w_ram_we_nxt       = 1'b0;
        w_ram_oe_nxt       = 1'b0;
        w_if_ack_nxt       = 1'b0;
        w_ls_ack_nxt       = 1'b0;
        w_if_rdata_nxt     = r_if_rdata;
        w_ls_rdata_nxt     = r_ls_rdata;
        // Round-robin: with both requesting, the port not granted last wins.
        w_pick_ls          = i_ls_req && (!i_if_req || !r_last_ls);

        case (r_state)
            ST_IDLE: begin
                if (i_if_req || i_ls_req) begin
                    w_state_nxt   = ST_ACCESS;
                    w_cnt_nxt     = CNT_W'(RAM_LAT - 1);
                    w_gnt_ls_nxt  = w_pick_ls;
                    w_last_ls_nxt = w_pick_ls;
                    if (w_pick_ls) begin
                        w_we_nxt       = i_ls_we;
                        w_bus_addr_nxt = i_ls_addr;
                        if (i_ls_we) begin
                            w_bus_wdata_nxt = i_ls_wdata;
                        end
                    end else begin
                        w_we_nxt       = 1'b0;
                        w_bus_addr_nxt = i_if_addr;
                    end
                    // Strobes rise together with the ACCESS state.
                    w_ram_cs_nxt       = 1'b1;
                    w_ram_we_nxt       = w_we_nxt;
                    w_ram_oe_nxt       = !w_we_nxt;
                    w_bus_wdata_oe_nxt = w_we_nxt;
                end
            end

            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    // Last strobe cycle: RAM data is valid now, capture and respond.
                    w_state_nxt = ST_RESP;
                    if (r_gnt_ls) begin
                        w_ls_ack_nxt = 1'b1;
                        if (!r_we) begin
                            w_ls_rdata_nxt = i_bus_rdata;
                        end
                    end else begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = i_bus_rdata;
                    end
                end else begin
                    w_cnt_nxt          = r_cnt - 1'b1;
                    w_ram_cs_nxt       = 1'b1;
                    w_ram_we_nxt       = r_we;
                    w_ram_oe_nxt       = !r_we;
                    w_bus_wdata_oe_nxt = r_we;
                end
            end

            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_if_ack       = r_if_ack;
    assign o_if_rdata     = r_if_rdata;
    assign o_ls_ack       = r_ls_ack;
    assign o_ls_rdata     = r_ls_rdata;
    assign o_bus_addr     = r_bus_addr;
    assign o_bus_wdata    = r_bus_wdata;
    assign o_bus_wdata_oe = r_bus_wdata_oe;
    assign o_ram_cs       = r_ram_cs;
    assign o_ram_we       = r_ram_we;
    assign o_ram_oe       = r_ram_oe;
    assign o_busy         = r_busy;

endmodule
